// File: rtl/vigna_axil_master_pkg.sv
// Shared AXI4-Lite response/protection constants and bridge FSM states.
package vigna_axil_master_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_DRAIN
    } state_t;

    // Anything but OKAY (EXOKAY included) is reported to the core as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/vigna_axil_timer.sv
// Response timeout counter: cleared outside the wait states, counts while waiting.
module vigna_axil_timer #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            localparam int unsigned CW = $clog2(TIMEOUT + 1);
            logic [CW-1:0] count;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn)     count <= '0;
                else if (clear)  count <= '0;
                else if (enable) count <= count + 1'b1;
            end

            // Fires on the TIMEOUT-th waiting cycle so req_ready lands TIMEOUT cycles after entry.
            assign expire = enable && (count == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/vigna_axil_master.sv
// Vigna valid/ready memory port to AXI4-Lite master bridge, one transaction in flight.
module vigna_axil_master
    import vigna_axil_master_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter logic [2:0]  PROT      = AXI_PROT_DEFAULT,
    parameter int unsigned TIMEOUT   = 1024,
    parameter bit          READ_ONLY = 1'b0,
    localparam int unsigned STRB_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic [DATA_W-1:0] req_rdata,
    output logic              req_err,
    output logic              busy,
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arprot,
    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    output logic              awvalid,
    input  logic              awready,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awprot,
    output logic              wvalid,
    input  logic              wready,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    input  logic              bvalid,
    output logic              bready,
    input  logic [1:0]        bresp
);

    state_t state, state_d;

    logic              arvalid_q, arvalid_d, awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d, awaddr_q, awaddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              aw_done_q, aw_done_d, w_done_q, w_done_d, is_wr_q, is_wr_d;
    logic              ready_q, ready_d, err_q, err_d;
    logic              req_is_wr, aw_hs, w_hs, wait_st, resp_seen, expire;

    assign req_is_wr = !READ_ONLY && (req_wstrb != '0);
    assign aw_hs     = awvalid_q && awready;
    assign w_hs      = wvalid_q && wready;
    assign wait_st   = (state == ST_RD_DATA) || (state == ST_WR_RESP);
    assign resp_seen = ((state == ST_RD_DATA) && rvalid) || ((state == ST_WR_RESP) && bvalid);

    vigna_axil_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .resetn (resetn),
        .clear  (!wait_st),
        .enable (wait_st && !resp_seen),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_d;
    end

    always_comb begin
        state_d   = state;
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        awvalid_d = awvalid_q;
        awaddr_d  = awaddr_q;
        wvalid_d  = wvalid_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        is_wr_d   = is_wr_q;
        ready_d   = 1'b0;
        err_d     = err_q;
        rdata_d   = rdata_q;
        case (state)
            ST_IDLE: begin
                if (req_valid && !ready_q) begin
                    is_wr_d = req_is_wr;
                    if (req_is_wr) begin
                        awaddr_d  = req_addr;
                        wdata_d   = req_wdata;
                        wstrb_d   = req_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = ST_WR_REQ;
                    end else begin
                        araddr_d  = req_addr;
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_ADDR;
                    end
                end
            end
            ST_RD_ADDR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (rvalid) begin
                    rdata_d = rdata;
                    err_d   = resp_is_err(rresp);
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (expire) begin
                    err_d   = 1'b1;
                    ready_d = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_WR_REQ: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // Done flags cover earlier handshakes; the *_hs terms cover this cycle's.
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (bvalid) begin
                    err_d   = resp_is_err(bresp);
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (expire) begin
                    err_d   = 1'b1;
                    ready_d = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (is_wr_q ? bvalid : rvalid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
            wvalid_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            is_wr_q   <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            awvalid_q <= awvalid_d;
            awaddr_q  <= awaddr_d;
            wvalid_q  <= wvalid_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            is_wr_q   <= is_wr_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    assign req_ready = ready_q;
    assign req_err   = err_q;
    assign req_rdata = rdata_q;
    assign busy      = (state != ST_IDLE);

    assign arvalid = arvalid_q;
    assign araddr  = araddr_q;
    assign arprot  = PROT;
    assign rready  = (state == ST_RD_DATA) || ((state == ST_DRAIN) && !is_wr_q);

    assign awvalid = READ_ONLY ? 1'b0 : awvalid_q;
    assign awaddr  = READ_ONLY ? '0 : awaddr_q;
    assign awprot  = READ_ONLY ? '0 : PROT;
    assign wvalid  = READ_ONLY ? 1'b0 : wvalid_q;
    assign wdata   = READ_ONLY ? '0 : wdata_q;
    assign wstrb   = READ_ONLY ? '0 : wstrb_q;
    assign bready  = READ_ONLY ? 1'b0 :
                     ((state == ST_WR_RESP) || ((state == ST_DRAIN) && is_wr_q));

endmodule

// File: tb/tb_vigna_axil_master.sv
// Directed bench for vigna_axil_master: a read/write instance with TIMEOUT=8 and a read-only instance.
module tb_vigna_axil_master;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    int          total = 0;
    int          passed = 0;

    logic        req_valid = 0, req_ready, req_err, busy;
    logic [31:0] req_addr = 0, req_wdata = 0, req_rdata;
    logic [3:0]  req_wstrb = 0;
    logic        arvalid, arready = 0, rvalid = 0, rready;
    logic [31:0] araddr, rdata = 0, awaddr, wdata;
    logic [2:0]  arprot, awprot;
    logic [1:0]  rresp = 0, bresp = 0;
    logic        awvalid, awready = 0, wvalid, wready = 0, bvalid = 0, bready;
    logic [3:0]  wstrb;

    logic        ro_req_valid = 0, ro_req_ready, ro_req_err, ro_busy;
    logic [31:0] ro_req_addr = 0, ro_req_wdata = 0, ro_req_rdata;
    logic [3:0]  ro_req_wstrb = 0;
    logic        ro_arvalid, ro_arready = 0, ro_rvalid = 0, ro_rready;
    logic [31:0] ro_araddr, ro_rdata = 0, ro_awaddr, ro_wdata;
    logic [2:0]  ro_arprot, ro_awprot;
    logic        ro_awvalid, ro_wvalid, ro_bready;
    logic [3:0]  ro_wstrb;
    int          ro_wr_seen = 0;

    always #5 clk = ~clk;

    vigna_axil_master #(.TIMEOUT(8)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_rdata(req_rdata),
        .req_err(req_err), .busy(busy),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp)
    );

    vigna_axil_master #(.READ_ONLY(1'b1)) dut_ro (
        .clk(clk), .resetn(resetn),
        .req_valid(ro_req_valid), .req_ready(ro_req_ready), .req_addr(ro_req_addr),
        .req_wdata(ro_req_wdata), .req_wstrb(ro_req_wstrb), .req_rdata(ro_req_rdata),
        .req_err(ro_req_err), .busy(ro_busy),
        .arvalid(ro_arvalid), .arready(ro_arready), .araddr(ro_araddr), .arprot(ro_arprot),
        .rvalid(ro_rvalid), .rready(ro_rready), .rdata(ro_rdata), .rresp(2'b00),
        .awvalid(ro_awvalid), .awready(1'b1), .awaddr(ro_awaddr), .awprot(ro_awprot),
        .wvalid(ro_wvalid), .wready(1'b1), .wdata(ro_wdata), .wstrb(ro_wstrb),
        .bvalid(1'b1), .bready(ro_bready), .bresp(2'b00)
    );

    always @(negedge clk) if (ro_awvalid || ro_wvalid || ro_bready) ro_wr_seen++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        total++; if ({arvalid, awvalid, wvalid} !== 3'b000) $display("FAIL reset_valids: got %b want 000", {arvalid, awvalid, wvalid}); else passed++;
        total++; if ({req_ready, req_err, busy} !== 3'b000) $display("FAIL reset_status: got %b want 000", {req_ready, req_err, busy}); else passed++;
        total++; if (req_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", req_rdata); else passed++;
        total++; if ({rready, bready} !== 2'b00) $display("FAIL reset_ready: got %b want 00", {rready, bready}); else passed++;
        @(negedge clk);
        resetn = 1'b1;
        step();
    endtask

    task automatic test_read();
        req_valid = 1; req_addr = 32'h1000; req_wstrb = 4'h0;
        step();
        total++; if ({arvalid, araddr} !== {1'b1, 32'h1000}) $display("FAIL rd_ar: got %b/%h want 1/00001000", arvalid, araddr); else passed++;
        total++; if ({busy, req_ready} !== 2'b10) $display("FAIL rd_busy: got %b want 10", {busy, req_ready}); else passed++;
        arready = 1;
        step();
        arready = 0;
        total++; if ({arvalid, rready} !== 2'b01) $display("FAIL rd_wait: got %b want 01", {arvalid, rready}); else passed++;
        step();
        rvalid = 1; rdata = 32'hDEADBEEF; rresp = 2'b00;
        step();
        rvalid = 0; req_valid = 0;
        total++; if ({req_ready, req_err, req_rdata} !== {2'b10, 32'hDEADBEEF}) $display("FAIL rd_done: got %b%b/%h want 10/deadbeef", req_ready, req_err, req_rdata); else passed++;
        step();
        total++; if ({req_ready, busy, arvalid} !== 3'b000) $display("FAIL rd_pulse: got %b want 000", {req_ready, busy, arvalid}); else passed++;
    endtask

    task automatic test_write_aw_first();
        req_valid = 1; req_addr = 32'h2004; req_wdata = 32'h12345678; req_wstrb = 4'b0011;
        step();
        total++; if ({awvalid, wvalid, awaddr, wdata, wstrb} !== {2'b11, 32'h2004, 32'h12345678, 4'b0011})
            $display("FAIL wr_issue: got %b%b/%h/%h/%b want 11/00002004/12345678/0011", awvalid, wvalid, awaddr, wdata, wstrb); else passed++;
        awready = 1;
        step();
        awready = 0;
        total++; if ({awvalid, wvalid, bready} !== 3'b010) $display("FAIL wr_aw_drop: got %b want 010", {awvalid, wvalid, bready}); else passed++;
        step();
        step();
        total++; if ({awvalid, wvalid} !== 2'b01) $display("FAIL wr_w_hold: got %b want 01", {awvalid, wvalid}); else passed++;
        wready = 1;
        step();
        wready = 0;
        total++; if ({wvalid, bready} !== 2'b01) $display("FAIL wr_resp_state: got %b want 01", {wvalid, bready}); else passed++;
        bvalid = 1; bresp = 2'b00;
        step();
        bvalid = 0; req_valid = 0;
        total++; if ({req_ready, req_err} !== 2'b10) $display("FAIL wr_done: got %b want 10", {req_ready, req_err}); else passed++;
        step();
    endtask

    task automatic test_write_w_first_and_same_cycle();
        req_valid = 1; req_addr = 32'h2100; req_wdata = 32'hA1B2C3D4; req_wstrb = 4'hF;
        step();
        wready = 1;
        step();
        wready = 0;
        total++; if ({awvalid, wvalid, bready} !== 3'b100) $display("FAIL wf_w_drop: got %b want 100", {awvalid, wvalid, bready}); else passed++;
        awready = 1;
        step();
        awready = 0;
        total++; if ({awvalid, wvalid, bready} !== 3'b001) $display("FAIL wf_resp: got %b want 001", {awvalid, wvalid, bready}); else passed++;
        bvalid = 1;
        step();
        bvalid = 0; req_valid = 0;
        total++; if ({req_ready, req_err} !== 2'b10) $display("FAIL wf_done: got %b want 10", {req_ready, req_err}); else passed++;
        step();
        req_valid = 1; req_addr = 32'h2200; req_wstrb = 4'b1000;
        step();
        awready = 1; wready = 1;
        step();
        total++; if ({awvalid, wvalid, bready} !== 3'b001) $display("FAIL sc_resp: got %b want 001", {awvalid, wvalid, bready}); else passed++;
        step();
        awready = 0; wready = 0;
        total++; if ({awvalid, wvalid, bready} !== 3'b001) $display("FAIL sc_no_dup: got %b want 001", {awvalid, wvalid, bready}); else passed++;
        bvalid = 1;
        step();
        bvalid = 0; req_valid = 0;
        total++; if ({req_ready, req_err} !== 2'b10) $display("FAIL sc_done: got %b want 10", {req_ready, req_err}); else passed++;
        step();
    endtask

    task automatic test_errors();
        req_valid = 1; req_addr = 32'h3000; req_wstrb = 4'h0;
        step();
        arready = 1;
        step();
        arready = 0; rvalid = 1; rdata = 32'hA5A5A5A5; rresp = 2'b10;
        step();
        rvalid = 0; rresp = 2'b00; req_valid = 0;
        total++; if ({req_ready, req_err, req_rdata} !== {2'b11, 32'hA5A5A5A5}) $display("FAIL err_rd: got %b%b/%h want 11/a5a5a5a5", req_ready, req_err, req_rdata); else passed++;
        step();
        req_valid = 1; req_addr = 32'h3004; req_wdata = 32'h0; req_wstrb = 4'h1;
        step();
        awready = 1; wready = 1;
        step();
        awready = 0; wready = 0; bvalid = 1; bresp = 2'b11;
        step();
        bvalid = 0; bresp = 2'b00; req_valid = 0;
        total++; if ({req_ready, req_err} !== 2'b11) $display("FAIL err_wr: got %b want 11", {req_ready, req_err}); else passed++;
        step();
    endtask

    task automatic test_timeout_drain();
        logic early = 0;
        req_valid = 1; req_addr = 32'h3800; req_wstrb = 4'h0;
        step();
        arready = 1;
        step();
        arready = 0;
        for (int i = 0; i < 8; i++) begin
            if (req_ready) early = 1;
            step();
        end
        total++; if (early !== 1'b0) $display("FAIL to_early: got %b want 0", early); else passed++;
        total++; if ({req_ready, req_err, req_rdata} !== {2'b11, 32'hA5A5A5A5}) $display("FAIL to_fire: got %b%b/%h want 11/a5a5a5a5", req_ready, req_err, req_rdata); else passed++;
        total++; if ({busy, rready} !== 2'b11) $display("FAIL to_drain: got %b want 11", {busy, rready}); else passed++;
        req_addr = 32'h4000;
        step();
        total++; if ({busy, arvalid, req_ready} !== 3'b100) $display("FAIL to_stall: got %b want 100", {busy, arvalid, req_ready}); else passed++;
        rvalid = 1; rdata = 32'hBAD0BAD0;
        step();
        rvalid = 0;
        total++; if ({req_ready, busy, req_rdata} !== {2'b00, 32'hA5A5A5A5}) $display("FAIL to_discard: got %b%b/%h want 00/a5a5a5a5", req_ready, busy, req_rdata); else passed++;
        step();
        total++; if ({arvalid, araddr} !== {1'b1, 32'h4000}) $display("FAIL to_next_ar: got %b/%h want 1/00004000", arvalid, araddr); else passed++;
        arready = 1;
        step();
        arready = 0; rvalid = 1; rdata = 32'hCAFEF00D;
        step();
        rvalid = 0; req_valid = 0;
        total++; if ({req_ready, req_err, req_rdata} !== {2'b10, 32'hCAFEF00D}) $display("FAIL to_next_rd: got %b%b/%h want 10/cafef00d", req_ready, req_err, req_rdata); else passed++;
        step();
    endtask

    task automatic test_read_only();
        ro_req_valid = 1; ro_req_addr = 32'h500; ro_req_wdata = 32'hFFFFFFFF; ro_req_wstrb = 4'hF;
        step();
        total++; if ({ro_arvalid, ro_araddr} !== {1'b1, 32'h500}) $display("FAIL ro_ar: got %b/%h want 1/00000500", ro_arvalid, ro_araddr); else passed++;
        ro_arready = 1;
        step();
        ro_arready = 0;
        total++; if ({ro_arvalid, ro_rready} !== 2'b01) $display("FAIL ro_wait: got %b want 01", {ro_arvalid, ro_rready}); else passed++;
        ro_rvalid = 1; ro_rdata = 32'h11223344;
        step();
        ro_rvalid = 0; ro_req_valid = 0;
        total++; if ({ro_req_ready, ro_req_err, ro_req_rdata} !== {2'b10, 32'h11223344}) $display("FAIL ro_done: got %b%b/%h want 10/11223344", ro_req_ready, ro_req_err, ro_req_rdata); else passed++;
        step();
        total++; if (ro_wr_seen !== 0) $display("FAIL ro_no_write: got %0d write-channel cycles want 0", ro_wr_seen); else passed++;
    endtask

    task automatic test_reset_mid();
        req_valid = 1; req_addr = 32'h6000; req_wstrb = 4'h0;
        step();
        total++; if (arvalid !== 1'b1) $display("FAIL mid_ar: got %b want 1", arvalid); else passed++;
        #2;
        resetn = 1'b0;
        #1;
        total++; if ({arvalid, req_ready, busy} !== 3'b000) $display("FAIL mid_reset: got %b want 000", {arvalid, req_ready, busy}); else passed++;
        req_valid = 0;
        @(negedge clk);
        resetn = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_aw_first();
        test_write_w_first_and_same_cycle();
        test_errors();
        test_timeout_drain();
        test_read_only();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

endmodule
